// File: rtl/pipelined_addsub.sv
// pipelined_addsub: chunked carry-chained add/subtract pipeline with ALU flags, tag and valid/ready handshake
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int L = STAGES - 1;
  logic adv;
  if (WIDTH % CHUNK != 0) begin : g_chk
    $fatal(1, "WIDTH must be a multiple of CHUNK");
  end
  for (genvar s = 0; s < STAGES; s++) begin : st
    localparam int RW = WIDTH - s * CHUNK;
    logic                   pv, pc;
    logic [RW-1:0]          pa, pb;
    logic [TAG_W-1:0]       pt;
    logic [CHUNK:0]         add;
    logic [(s+1)*CHUNK-1:0] r_n, r_q, r_d;
    logic                   v_q, v_d, c_q, c_d;
    logic [TAG_W-1:0]       t_q, t_d;
    if (s == 0) begin : src
      assign pv  = in_valid && in_ready;
      assign pa  = in_a;
      assign pb  = in_op[0] ? ~in_b : in_b;
      assign pc  = in_op[1] ? in_cin : in_op[0];
      assign pt  = in_tag;
      assign r_n = add[CHUNK-1:0];
    end else begin : src
      assign pv  = st[s-1].v_q;
      assign pa  = st[s-1].sk.a_q;
      assign pb  = st[s-1].sk.b_q;
      assign pc  = st[s-1].c_q;
      assign pt  = st[s-1].t_q;
      assign r_n = {add[CHUNK-1:0], st[s-1].r_q};
    end
    assign add = {1'b0, pa[CHUNK-1:0]} + {1'b0, pb[CHUNK-1:0]} + {{CHUNK{1'b0}}, pc};
    always_comb begin
      v_d = adv ? pv : v_q;
      c_d = adv ? add[CHUNK] : c_q;
      t_d = adv ? pt : t_q;
      r_d = adv ? r_n : r_q;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        t_q <= '0;
        r_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        t_q <= t_d;
        r_q <= r_d;
      end
    end
    // skew registers shrink by one chunk per stage; the last stage needs none
    if (s < L) begin : sk
      logic [RW-CHUNK-1:0] a_q, a_d, b_q, b_d;
      always_comb begin
        a_d = adv ? pa[RW-1:CHUNK] : a_q;
        b_d = adv ? pb[RW-1:CHUNK] : b_q;
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end
  logic ovf_q, ovf_d, zero_q, zero_d;
  always_comb begin
    ovf_d  = adv ? (st[L].pa[CHUNK-1] ^ st[L].pb[CHUNK-1] ^ st[L].add[CHUNK-1] ^ st[L].add[CHUNK]) : ovf_q;
    zero_d = adv ? (st[L].r_n == '0) : zero_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign adv       = !st[L].v_q || out_ready;
  assign in_ready  = adv && !rst;
  assign out_valid = st[L].v_q;
  assign out_sum   = st[L].r_q;
  assign out_carry = st[L].c_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_neg   = out_sum[WIDTH-1];
  assign out_tag   = st[L].t_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench for pipelined_addsub with directed vectors
module tb_pipelined_addsub;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, in_cin = 0;
  logic [15:0] in_a = 0, in_b = 0, out_sum;
  logic [1:0] in_op = 0;
  logic [3:0] in_tag = 0, out_tag;
  logic out_valid, out_ready = 1, out_carry, out_ovf, out_zero, out_neg;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {
    logic [15:0] s;
    logic c, o, z, n;
    logic [3:0] t;
    int cy;
    bit lat;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  pipelined_addsub #(.WIDTH(16), .CHUNK(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero),
    .out_neg(out_neg), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp_v);
    end
  endtask

  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic [1:0] op, logic cin, logic [3:0] t);
    logic [15:0] bb;
    logic [16:0] f;
    exp_t e;
    bb = op[0] ? ~b : b;
    f = {1'b0, a} + {1'b0, bb} + {16'b0, (op[1] ? cin : op[0])};
    e.s = f[15:0];
    e.c = f[16];
    e.o = (a[15] == bb[15]) && (f[15] != a[15]);
    e.z = (f[15:0] == 16'h0);
    e.n = f[15];
    e.t = t;
    e.cy = 0;
    e.lat = 0;
    return e;
  endfunction

  // called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                      input logic cin, input exp_t e, input bit lat);
    int n = 0;
    bit acc = 0;
    int ac = 0;
    in_valid = 1; in_a = a; in_b = b; in_op = op; in_cin = cin; in_tag = e.t;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      ac = cyc;
      @(posedge clk);
      #1;
      if (!acc && ++n > 50) begin
        total++; bad++;
        $display("FAIL accept_timeout tag=%h", e.t);
        break;
      end
    end
    if (acc) begin
      e.cy = ac;
      e.lat = lat;
      q.push_back(e);
    end
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_left", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out got sum=%h tag=%h want=none", out_sum, out_tag);
      end else begin
        mon_e = q.pop_front();
        check("result", {out_sum, out_carry, out_ovf, out_zero, out_neg, out_tag},
              {mon_e.s, mon_e.c, mon_e.o, mon_e.z, mon_e.n, mon_e.t});
        if (mon_e.lat) check("latency", cyc, mon_e.cy + 4);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {out_valid, out_sum, out_carry, out_ovf, out_zero, out_neg, out_tag}, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 0;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;
    send(16'hFFFF, 16'h0001, 2'b00, 1'b0, '{s:16'h0000, c:1, o:0, z:1, n:0, t:4'h1, cy:0, lat:0}, 1);
    send(16'h8000, 16'h0001, 2'b01, 1'b0, '{s:16'h7FFF, c:1, o:1, z:0, n:0, t:4'h2, cy:0, lat:0}, 1);
    send(16'h0001, 16'h0002, 2'b01, 1'b0, '{s:16'hFFFF, c:0, o:0, z:0, n:1, t:4'h3, cy:0, lat:0}, 1);
    send(16'h7FFF, 16'h0000, 2'b10, 1'b1, '{s:16'h8000, c:0, o:1, z:0, n:1, t:4'h4, cy:0, lat:0}, 1);
    send(16'h0005, 16'h0005, 2'b11, 1'b0, '{s:16'hFFFF, c:0, o:0, z:0, n:1, t:4'h5, cy:0, lat:0}, 1);
    drain();
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a, b;
      a = 16'(i * 16'h2345 + 16'h0F0F);
      b = 16'(16'hC3A5 ^ (i << 5));
      send(a, b, 2'(i), 1'(i >> 1), model(a, b, 2'(i), 1'(i >> 1), 4'(i)), 1);
    end
    drain();
    out_ready = 0;
    for (int i = 0; i < 4; i++)
      send(16'(16'h1000 * i + 16'h00FF), 16'h0F01, 2'b00, 1'b0,
           model(16'(16'h1000 * i + 16'h00FF), 16'h0F01, 2'b00, 1'b0, 4'(8 + i)), 0);
    repeat (5) begin
      @(negedge clk);
      check("stall_hold", {out_valid, in_ready, out_sum, out_tag}, {1'b1, 1'b0, q[0].s, q[0].t});
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    send(16'hABCD, 16'h1234, 2'b01, 1'b0, model(16'hABCD, 16'h1234, 2'b01, 1'b0, 4'hC), 0);
    drain();
    for (int i = 0; i < 3; i++)
      send(16'(16'h0101 * i), 16'h0202, 2'b00, 1'b0, model(16'(16'h0101 * i), 16'h0202, 2'b00, 1'b0, 4'(13 + i)), 0);
    rst = 1;
    q.delete();
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 0);
    @(negedge clk);
    check("rst_hold_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 0;
    send(16'h1234, 16'h1111, 2'b00, 1'b0, '{s:16'h2345, c:0, o:0, z:0, n:0, t:4'h6, cy:0, lat:0}, 1);
    drain();
    repeat (8) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
